paralelo_serial_tx: RTL and testbench
=====================================

# paralelo_serial_tx

Parallel-to-serial transmitter for the PHY lane: serializes one 8-bit symbol every 8 cycles of `clk_32f`, MSB first, onto a single serial line. It is the TX end of the serial link whose RX end aligns on COM (0xBC) symbols and then deserializes bytes. After reset it sends a fixed run of COM symbols so the receiver can lock. It then sends upstream data bytes when they are offered, and IDLE (0x7C) symbols when no byte is offered.

## Interface
- `COM`, 8'hBC: alignment symbol sent during SYNC.
- `IDLE`, 8'h7C: filler symbol sent in ACTIVE when no byte is offered.
- `SYNC_COUNT`, 4: number of COM symbols sent after reset; legal range 1..15.

- `clk_32f` input 1: bit clock; the only clock. All logic updates on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `data_in` input 8: byte to send; must be stable while `valid_in`=1 and no transfer has occurred.
- `valid_in` input 1: upstream offers `data_in`.
- `ready` output 1: combinational, = (state==ACTIVE && bit_cnt==0). A transfer occurs on an edge where `ready`&&`valid_in`.
- `data_out` output 1: serial line; registered, equal to shreg[7].
- `tx_active` output 1: registered; 1 while state==ACTIVE.

## Operation
- Internal registers:
  - `bit_cnt[2:0]`
  - `shreg[7:0]`
  - `sym_cnt[3:0]`
  - state ∈ {SYNC, ACTIVE}
- On an edge with `reset`=0:
  - bit_cnt=0, shreg=0, sym_cnt=0, state=SYNC.
  - Outputs are then data_out=0, tx_active=0, ready=0.
- On an edge with `reset`=1:
  - bit_cnt <= bit_cnt+1, wrapping 7→0.
  - If bit_cnt==0 (load edge): shreg <= next symbol. Otherwise: shreg <= {shreg[6:0],1'b0}.
- Next symbol at a load edge:
  - SYNC: load COM and increment sym_cnt. If sym_cnt==SYNC_COUNT-1, go to ACTIVE and clear sym_cnt.
  - ACTIVE with valid_in=1: load data_in; this is the transfer.
  - ACTIVE with valid_in=0: load IDLE.
- The only state transitions are SYNC→ACTIVE (as above) and any state→SYNC on reset. There is no return to SYNC without reset.
- `valid_in` is ignored during SYNC; no transfer is possible there.
- No byte is dropped or duplicated. A byte offered mid-symbol waits for the next load edge, and upstream must hold it.

## Timing
- Let L0 be the first edge with reset=1 after reset.
- Load edges occur at L0+8k.
- COM is loaded at L0, L0+8, …, L0+8·(SYNC_COUNT-1).
- tx_active rises after edge L0+8·(SYNC_COUNT-1), i.e. during transmission of the last COM.
- With SYNC_COUNT=4, ready is first 1 in the cycle before edge L0+32.
- ready is 1 for exactly 1 of every 8 cycles in ACTIVE.
- Latency, for a byte accepted at edge E:
  - bit7 on data_out in the cycle after E,
  - bit k after edge E+(7-k),
  - last bit after E+7,
  - next byte's MSB after E+8.
- The line has no gaps: back-to-back transfers give a continuous 8-bit-per-symbol stream.
- Reset mid-symbol: the current symbol is aborted and data_out=0 after the reset edge. Any byte not yet transferred is not consumed. A transfer on the same edge as reset=0 cannot occur, because reset has priority.
- valid_in rising exactly on a load edge in ACTIVE: the byte is transferred on that edge.

## Test plan
- Startup: reset low for 3 edges, then high, valid_in=0.
  - Required: data_out = 10111100 four times (32 cycles), then 01111100 repeating.
  - tx_active=1 from after edge L0+24.
  - ready=0 before L0+31.
- Streaming: in ACTIVE, valid_in=1 constant and data_in=0xA4 changed to 0x3D right after a transfer.
  - Required: ready pulses every 8 cycles; data_out = 10100100 then 00111101, with no gaps.
- Hold: valid_in rises with data_in=0x9E at bit_cnt=3.
  - Required: no transfer until the next load edge; then 10011110 is sent exactly once; the following symbol is IDLE if valid_in dropped.
- Interleave: offer 0xB8, withhold for one symbol, then offer 0x3D.
  - Required: data_out sequence 10111000, 01111100, 00111101.
- Reset mid-byte: assert reset for 1 edge after 3 bits of 0xA4.
  - Required: data_out=0 and tx_active=0 after the reset edge.
  - Then a full 4×COM resync, and the byte is not resent unless re-offered.
- Parameter: SYNC_COUNT=1.
  - Required: one COM, then tx_active=1 after L0, and ready first high in the cycle before edge L0+8.

Source files
------------

// File: rtl/paralelo_serial_tx.sv
// paralelo_serial_tx: serializes one 8-bit symbol every 8 clk_32f cycles,
// MSB first; COM burst after reset for receiver lock, then data or IDLE.
// Ports:
//   clk_32f   - bit clock, rising edge
//   reset     - synchronous, active-low
//   data_in   - byte offered by upstream, held until transferred
//   valid_in  - upstream offers data_in
//   ready     - high in the cycle before a load edge while ACTIVE
//   data_out  - serial line (MSB of the shift register)
//   tx_active - high once the COM burst has been fully loaded
module paralelo_serial_tx #(
    parameter logic [7:0] COM        = 8'hBC,
    parameter logic [7:0] IDLE       = 8'h7C,
    parameter int         SYNC_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready,
    output logic       data_out,
    output logic       tx_active
);

    localparam logic [0:0] SYNC   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [3:0] SYNC_LAST = 4'(SYNC_COUNT - 1);

    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [3:0] sym_cnt;
    logic [0:0] state;

    logic load;

    assign load      = (bit_cnt == 3'd0);
    assign ready     = (state == ACTIVE) && load;
    assign data_out  = shreg[7];
    assign tx_active = (state == ACTIVE);

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            sym_cnt <= 4'd0;
            state   <= SYNC;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (load) begin
                unique case (state)
                    SYNC: begin
                        shreg <= COM;
                        // Last COM of the burst: data may follow
                        // on the very next load edge.
                        if (sym_cnt == SYNC_LAST) begin
                            state   <= ACTIVE;
                            sym_cnt <= 4'd0;
                        end else begin
                            sym_cnt <= sym_cnt + 4'd1;
                        end
                    end
                    ACTIVE: begin
                        shreg <= valid_in ? data_in : IDLE;
                    end
                    default: begin
                        shreg <= 8'h00;
                        state <= SYNC;
                    end
                endcase
            end else begin
                shreg <= {shreg[6:0], 1'b0};
            end
        end
    end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// tb_paralelo_serial_tx: drives two transmitters (SYNC_COUNT 4 and 1)
// with shared stimulus and checks them against a symbol-stream model.
module tb_paralelo_serial_tx;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;

    logic [1:0] ready;
    logic [1:0] data_out;
    logic [1:0] tx_active;

    int checks = 0;
    int errors = 0;

    paralelo_serial_tx #(.SYNC_COUNT(4)) dut4 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready[0]),
        .data_out (data_out[0]),
        .tx_active(tx_active[0])
    );

    paralelo_serial_tx #(.SYNC_COUNT(1)) dut1 (
        .clk_32f  (clk_32f),
        .reset    (reset),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready    (ready[1]),
        .data_out (data_out[1]),
        .tx_active(tx_active[1])
    );

    always #5 clk_32f = ~clk_32f;

    // Reference: n counts edges since reset release; every 8th edge
    // picks a symbol (COM for the first sc symbols, else data/IDLE),
    // and the line shows that symbol's bits by position.
    int         sc  [2] = '{4, 1};
    int         n   [2] = '{0, 0};
    logic [7:0] sym [2] = '{8'h00, 8'h00};
    int         xfers [2] = '{0, 0};

    always @(posedge clk_32f) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                n[k]   = 0;
                sym[k] = 8'h00;
            end else begin
                if (n[k] % 8 == 0) begin
                    if (n[k] / 8 < sc[k]) begin
                        sym[k] = COM;
                    end else if (valid_in) begin
                        sym[k] = data_in;
                        xfers[k] = xfers[k] + 1;
                    end else begin
                        sym[k] = IDLE;
                    end
                end
                n[k] = n[k] + 1;
            end
        end
    end

    function automatic logic exp_do(int k);
        if (n[k] == 0) return 1'b0;
        return sym[k][7 - ((n[k] - 1) % 8)];
    endfunction

    function automatic logic exp_act(int k);
        return n[k] >= 8 * (sc[k] - 1) + 1;
    endfunction

    function automatic logic exp_rdy(int k);
        return (n[k] % 8 == 0) && (n[k] >= 8 * sc[k]);
    endfunction

    task automatic check_all(string tag);
        for (int k = 0; k < 2; k++) begin
            logic e;
            e = exp_do(k);
            checks++;
            assert (data_out[k] === e) else begin
                errors++;
                $error("FAIL %s data_out[%0d] got %b exp %b n=%0d",
                       tag, k, data_out[k], e, n[k]);
            end
            e = exp_act(k);
            checks++;
            assert (tx_active[k] === e) else begin
                errors++;
                $error("FAIL %s tx_active[%0d] got %b exp %b n=%0d",
                       tag, k, tx_active[k], e, n[k]);
            end
            e = exp_rdy(k);
            checks++;
            assert (ready[k] === e) else begin
                errors++;
                $error("FAIL %s ready[%0d] got %b exp %b n=%0d",
                       tag, k, ready[k], e, n[k]);
            end
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk_32f);
        @(negedge clk_32f);
        check_all(tag);
    endtask

    task automatic ticks(int c, string tag);
        for (int i = 0; i < c; i++) tick(tag);
    endtask

    // Offer a byte and hold it until the edge that takes it.
    task automatic send(logic [7:0] b, string tag);
        int w;
        data_in  = b;
        valid_in = 1'b1;
        w = 0;
        while (!ready[0] && w < 16) begin
            tick(tag);
            w++;
        end
        checks++;
        assert (ready[0] === 1'b1) else begin
            errors++;
            $error("FAIL %s ready timeout got %b exp 1", tag, ready[0]);
        end
        tick(tag);
    endtask

    initial begin
        @(negedge clk_32f);
        reset = 1'b0;
        ticks(3, "reset");
        reset = 1'b1;
        ticks(48, "startup");

        send(8'hA4, "stream");
        send(8'h3D, "stream");
        valid_in = 1'b0;
        ticks(10, "stream_tail");

        while (!ready[0]) tick("align");
        ticks(3, "hold_pre");
        send(8'h9E, "hold");
        valid_in = 1'b0;
        ticks(16, "hold_post");

        send(8'hB8, "ilv");
        valid_in = 1'b0;
        ticks(8, "ilv_gap");
        send(8'h3D, "ilv");
        valid_in = 1'b0;
        ticks(8, "ilv_tail");

        send(8'hA4, "rst_mid");
        valid_in = 1'b0;
        ticks(2, "rst_mid");
        reset = 1'b0;
        tick("rst_edge");
        checks++;
        assert (data_out[0] === 1'b0 && tx_active[0] === 1'b0)
        else begin
            errors++;
            $error("FAIL rst_edge out/act got %b%b exp 00",
                   data_out[0], tx_active[0]);
        end
        reset = 1'b1;
        ticks(48, "resync");

        for (int i = 0; i < 400; i++) begin
            logic go;
            go = ready[0] && valid_in;
            tick("rand");
            if (go || !valid_in) begin
                valid_in = ($urandom_range(0, 3) != 0);
                data_in  = 8'($urandom);
            end
        end
        valid_in = 1'b0;
        ticks(10, "drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
